// File: rtl/pllcfg_spi_pkg.sv
// Shared constants for the PLL-config SPI sequencer: master register map,
// control/status bit positions and sequencer FSM state codes.
package pllcfg_spi_pkg;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;
    localparam logic [2:0] ADDR_SSEL    = 3'd5;
    localparam logic [2:0] ADDR_EOPVAL  = 3'd6;

    localparam int CTRL_SSO  = 10;
    localparam int STAT_TMT  = 5;
    localparam int STAT_TRDY = 6;
    localparam int STAT_RRDY = 7;

    localparam logic [15:0] CTRL_SSO_ON = 16'h0400;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR_SS     = 4'd1;
    localparam logic [3:0] S_CTRL_ON   = 4'd2;
    localparam logic [3:0] S_WAIT_TX   = 4'd3;
    localparam logic [3:0] S_WR_DATA   = 4'd4;
    localparam logic [3:0] S_WAIT_RRDY = 4'd5;
    localparam logic [3:0] S_RD_DATA   = 4'd6;
    localparam logic [3:0] S_RX_HOLD   = 4'd7;
    localparam logic [3:0] S_CTRL_OFF  = 4'd8;
    localparam logic [3:0] S_CLR_ST    = 4'd9;
    localparam logic [3:0] S_DONE      = 4'd10;

endpackage

// File: rtl/pllcfg_spi_sequencer_if.sv
// SPI master register-port bus (Avalon-style, active-low strobes).
// master: sequencer side drives select/addr/strobes/wdata; slave: SPI master.
interface pllcfg_spi_sequencer_if;

    logic        spi_select;
    logic [2:0]  spi_addr;
    logic        spi_write_n;
    logic        spi_read_n;
    logic [15:0] spi_wdata;
    logic [15:0] spi_rdata;
    logic        spi_rrdy;

    modport master (
        output spi_select, spi_addr, spi_write_n, spi_read_n, spi_wdata,
        input  spi_rdata, spi_rrdy
    );

    modport slave (
        input  spi_select, spi_addr, spi_write_n, spi_read_n, spi_wdata,
        output spi_rdata, spi_rrdy
    );

endinterface

// File: rtl/pllcfg_spi_bus_access.sv
// Register-port access engine: each access holds select/strobe/addr/wdata
// for exactly 2 cycles then idles >=1 cycle. Ports: start/we/addr/wdata in,
// ready (may start), ack (1-cycle, gap cycle), first (1st assert cycle), rdata.
module pllcfg_spi_bus_access (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic        first,
    output logic [15:0] rdata,
    pllcfg_spi_sequencer_if.master spi
);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_A1   = 2'd1;
    localparam logic [1:0] PH_A2   = 2'd2;
    localparam logic [1:0] PH_GAP  = 2'd3;

    logic [1:0]  ph;
    logic        we_q;
    logic [2:0]  addr_q;
    logic [15:0] wdata_q;
    logic        active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph      <= PH_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            unique case (ph)
                PH_IDLE, PH_GAP: begin
                    if (start) begin
                        ph      <= PH_A1;
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                    end else begin
                        ph <= PH_IDLE;
                    end
                end
                PH_A1: ph <= PH_A2;
                PH_A2: begin
                    ph <= PH_GAP;
                    // edge ending the 2nd asserted cycle
                    if (!we_q) rdata <= spi.spi_rdata;
                end
                default: ph <= PH_IDLE;
            endcase
        end
    end

    assign active          = (ph == PH_A1) || (ph == PH_A2);
    assign ready           = (ph == PH_IDLE) || (ph == PH_GAP);
    assign ack             = (ph == PH_GAP);
    assign first           = (ph == PH_A1);
    assign spi.spi_select  = active;
    assign spi.spi_write_n = !(active && we_q);
    assign spi.spi_read_n  = !(active && !we_q);
    assign spi.spi_addr    = addr_q;
    assign spi.spi_wdata   = wdata_q;

endmodule

// File: rtl/pllcfg_spi_sequencer.sv
// Hardware SPI transaction sequencer for the PLL-config SPI master: ssel, SSO on,
// per-byte write/RRDY wait/read, SSO off, status clear. Ports: cmd (valid/ready,
// len, ss), tx/rx byte handshakes, busy/done/err_timeout, spi register bus.
module pllcfg_spi_sequencer
    import pllcfg_spi_pkg::*;
#(
    parameter int NUM_SLAVES  = 1,
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 1023,
    localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [NUM_SLAVES-1:0] cmd_ss,
    input  logic [7:0]            tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    pllcfg_spi_sequencer_if.master spi
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [3:0]            state;
    logic                  sent;
    logic [LEN_W-1:0]      len_left;
    logic [NUM_SLAVES-1:0] ss_q;
    logic [7:0]            tx_q;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  err_q;

    logic        acc_req;
    logic        acc_we;
    logic [2:0]  acc_addr;
    logic [15:0] acc_wdata;
    logic        eng_start;
    logic        eng_ready;
    logic        eng_ack;
    logic        eng_first;
    logic [15:0] eng_rdata;
    logic        acc_done;
    logic [7:0]  unused_rdata_hi;

    always_comb begin
        acc_req   = 1'b0;
        acc_we    = 1'b1;
        acc_addr  = ADDR_RXDATA;
        acc_wdata = '0;
        unique case (state)
            S_WR_SS: begin
                acc_req  = 1'b1;
                acc_addr = ADDR_SSEL;
                acc_wdata[NUM_SLAVES-1:0] = ss_q;
            end
            S_CTRL_ON: begin
                acc_req   = 1'b1;
                acc_addr  = ADDR_CONTROL;
                acc_wdata = CTRL_SSO_ON;
            end
            S_WR_DATA: begin
                acc_req   = 1'b1;
                acc_addr  = ADDR_TXDATA;
                acc_wdata = {8'h00, tx_q};
            end
            S_RD_DATA: begin
                acc_req  = 1'b1;
                acc_we   = 1'b0;
                acc_addr = ADDR_RXDATA;
            end
            S_CTRL_OFF: begin
                acc_req  = 1'b1;
                acc_addr = ADDR_CONTROL;
            end
            S_CLR_ST: begin
                acc_req  = 1'b1;
                acc_addr = ADDR_STATUS;
            end
            default: ;
        endcase
    end

    // one access per access-state; sent marks it as issued
    assign eng_start = acc_req && !sent && eng_ready;
    assign acc_done  = eng_ack && sent;

    pllcfg_spi_bus_access u_bus (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (eng_start),
        .we      (acc_we),
        .addr    (acc_addr),
        .wdata   (acc_wdata),
        .ready   (eng_ready),
        .ack     (eng_ack),
        .first   (eng_first),
        .rdata   (eng_rdata),
        .spi     (spi)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            sent     <= 1'b0;
            len_left <= '0;
            ss_q     <= '0;
            tx_q     <= '0;
            tmo_cnt  <= '0;
            err_q    <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            if (eng_start) sent <= 1'b1;
            if (acc_done)  sent <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        ss_q     <= cmd_ss;
                        len_left <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
                        err_q    <= 1'b0;
                        state    <= S_WR_SS;
                    end
                end
                S_WR_SS:   if (acc_done) state <= S_CTRL_ON;
                S_CTRL_ON: if (acc_done) state <= S_WAIT_TX;
                S_WAIT_TX: begin
                    if (tx_valid) begin
                        tx_q  <= tx_data;
                        state <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (acc_done) begin
                        tmo_cnt <= '0;
                        state   <= S_WAIT_RRDY;
                    end
                end
                S_WAIT_RRDY: begin
                    if (spi.spi_rrdy) begin
                        state <= S_RD_DATA;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        err_q <= 1'b1;
                        state <= S_CTRL_OFF;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (acc_done) begin
                        rx_data  <= eng_rdata[7:0];
                        rx_valid <= 1'b1;
                        len_left <= len_left - 1'b1;
                        state    <= S_RX_HOLD;
                    end
                end
                S_RX_HOLD: begin
                    if (rx_ready) begin
                        rx_valid <= 1'b0;
                        state    <= (len_left != '0) ? S_WAIT_TX : S_CTRL_OFF;
                    end
                end
                S_CTRL_OFF: if (acc_done) state <= S_CLR_ST;
                S_CLR_ST:   if (acc_done) state <= S_DONE;
                S_DONE:     state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

    assign unused_rdata_hi = eng_rdata[15:8];
    assign cmd_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign err_timeout = done && err_q;
    assign tx_ready    = (state == S_WR_DATA) && eng_first;

endmodule
